// File: rtl/cfg_master.sv
// ---------------------------------------------------------------------------
// cfg_master
//   Initiator for the broadcast config write bus. Upstream write requests are
//   buffered in a small in-order FIFO and replayed as single-cycle
//   cfg_en/cfg_addr/cfg_data strobes. GAP_CYCLES forced idle cycles follow
//   every strobe.
//
// Ports
//   clk, rst             clock (rising edge) / async active-high reset
//   req_valid/req_ready  upstream handshake; push on valid && ready
//   req_addr, req_data   request payload
//   flush                synchronous discard of buffered requests
//   cfg_en               write strobe, one cycle per write (registered)
//   cfg_addr, cfg_data   strobe payload, held between strobes (registered)
//   busy                 buffered or in-flight work exists
//   fifo_level           buffered entry count
//   wr_count             total strobes issued, wraps
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | no strobe high, no gap pending; launch when FIFO non-empty
// ISSUE | cfg_en high this cycle
// GAP   | enforced low cycles; gap_cnt counts down to 0
// ---------------------------------------------------------------------------
module cfg_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_data,
    input  logic                          flush,
    output logic                          cfg_en,
    output logic [ADDR_WIDTH-1:0]         cfg_addr,
    output logic [DATA_WIDTH-1:0]         cfg_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   wr_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [7:0] GAP_LOAD = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        gap_cnt, gap_cnt_nxt;
    logic              launch;

    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic                  push, pop, fifo_empty;

    // Full blocks acceptance even if a pop happens on the same edge.
    assign req_ready  = (fifo_level < DEPTH_L) && !flush;
    assign push       = req_valid && req_ready;
    assign pop        = launch;
    assign fifo_empty = (fifo_level == '0);
    assign busy       = !fifo_empty || cfg_en || (state != IDLE);

    // -----------------------------------------------------------------------
    // FIFO storage (no reset needed: contents are qualified by fifo_level)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= req_addr;
            mem_data[wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        launch      = 1'b0;
        if (flush) begin
            state_nxt   = IDLE;
            gap_cnt_nxt = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        launch    = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
                ISSUE: begin
                    if (HAS_GAP) begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_LOAD;
                    end else if (!fifo_empty) begin
                        launch    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                GAP: begin
                    // Last gap cycle launches directly so the low time is
                    // exactly GAP_CYCLES with a non-empty FIFO.
                    if (gap_cnt == 8'd0) begin
                        if (!fifo_empty) begin
                            launch    = 1'b1;
                            state_nxt = ISSUE;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        gap_cnt_nxt = gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    gap_cnt_nxt = 8'd0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registered bus outputs; payload only moves when a strobe launches
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_en   <= 1'b0;
            cfg_addr <= '0;
            cfg_data <= '0;
            wr_count <= 16'd0;
        end else begin
            cfg_en <= launch;
            if (launch) begin
                cfg_addr <= mem_addr[rd_ptr];
                cfg_data <= mem_data[rd_ptr];
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cfg_master.sv
// ---------------------------------------------------------------------------
// tb_cfg_master
//   Three cfg_master instances (GAP_CYCLES 0, 3, 5) share one stimulus
//   stream. A queue/timestamp reference model predicts every output of every
//   instance each cycle; directed tables and sequences cover the corner cases.
// ---------------------------------------------------------------------------
module tb_cfg_master;

    localparam int NI    = 3;
    localparam int DEPTH = 4;
    localparam int G0    = 0;
    localparam int G1    = 3;
    localparam int G2    = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        flush;
    logic [31:0] req_addr;
    logic [31:0] req_data;

    logic        req_ready  [NI];
    logic        cfg_en     [NI];
    logic        busy       [NI];
    logic [31:0] cfg_addr   [NI];
    logic [31:0] cfg_data   [NI];
    logic [2:0]  fifo_level [NI];
    logic [15:0] wr_count   [NI];

    always #5 clk = ~clk;

    cfg_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(G0)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_addr(req_addr), .req_data(req_data), .flush(flush),
        .cfg_en(cfg_en[0]), .cfg_addr(cfg_addr[0]), .cfg_data(cfg_data[0]),
        .busy(busy[0]), .fifo_level(fifo_level[0]), .wr_count(wr_count[0]));

    cfg_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(G1)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_addr(req_addr), .req_data(req_data), .flush(flush),
        .cfg_en(cfg_en[1]), .cfg_addr(cfg_addr[1]), .cfg_data(cfg_data[1]),
        .busy(busy[1]), .fifo_level(fifo_level[1]), .wr_count(wr_count[1]));

    cfg_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(G2)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[2]),
        .req_addr(req_addr), .req_data(req_data), .flush(flush),
        .cfg_en(cfg_en[2]), .cfg_addr(cfg_addr[2]), .cfg_data(cfg_data[2]),
        .busy(busy[2]), .fifo_level(fifo_level[2]), .wr_count(wr_count[2]));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: actual %0h required %0h (t=%0t)", nm, i, act, exp, $time);
        end
    endtask

    function automatic int gap_of(input int i);
        case (i)
            0:       return G0;
            1:       return G1;
            default: return G2;
        endcase
    endfunction

    // ------------------------- reference model ----------------------------
    // A strobe may launch at edge e when the buffer is non-empty, no flush is
    // present, and at least GAP+1 edges have passed since the previous launch
    // (a flush or reset forgets the previous launch).
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq [NI][$];
    int          last_l  [NI];
    bit          has_l   [NI];
    bit          m_en    [NI];
    bit          m_ready [NI];
    logic [31:0] m_addr  [NI];
    logic [31:0] m_data  [NI];
    logic [15:0] m_wr    [NI];
    int          edge_n = 0;

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            has_l[i]  = 1'b0;
            last_l[i] = 0;
            m_en[i]   = 1'b0;
            m_addr[i] = '0;
            m_data[i] = '0;
            m_wr[i]   = '0;
        end
    endtask

    function automatic bit m_busy(input int i);
        return (mq[i].size() != 0) || (has_l[i] && (edge_n - last_l[i]) <= gap_of(i));
    endfunction

    // Called at posedge+1 with inputs already driven; returns at posedge+1.
    task automatic step();
        ent_t e;
        bit   lch;
        #3;
        for (int i = 0; i < NI; i++) begin
            m_ready[i] = (mq[i].size() < DEPTH) && !flush;
            chk("req_ready", i, req_ready[i], m_ready[i]);
        end
        @(posedge clk);
        #1;
        edge_n++;
        for (int i = 0; i < NI; i++) begin
            lch = !flush && (mq[i].size() > 0) &&
                  (!has_l[i] || (edge_n - last_l[i]) > gap_of(i));
            if (flush) begin
                mq[i].delete();
                has_l[i] = 1'b0;
            end else if (lch) begin
                e         = mq[i].pop_front();
                m_addr[i] = e.a;
                m_data[i] = e.d;
                m_wr[i]   = m_wr[i] + 16'd1;
                last_l[i] = edge_n;
                has_l[i]  = 1'b1;
            end
            m_en[i] = lch;
            if (req_valid && m_ready[i]) mq[i].push_back({req_addr, req_data});
            chk("cfg_en",     i, cfg_en[i],     m_en[i]);
            chk("cfg_addr",   i, cfg_addr[i],   m_addr[i]);
            chk("cfg_data",   i, cfg_data[i],   m_data[i]);
            chk("fifo_level", i, fifo_level[i], mq[i].size());
            chk("wr_count",   i, wr_count[i],   m_wr[i]);
            chk("busy",       i, busy[i],       m_busy(i));
        end
    endtask

    task automatic drain();
        req_valid = 1'b0;
        flush     = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (!m_busy(0) && !m_busy(1) && !m_busy(2)) break;
            step();
        end
        for (int i = 0; i < NI; i++) chk("drain_busy", i, busy[i], 0);
    endtask

    // ------------------------- directed table (GAP 0) ---------------------
    typedef struct {
        bit          v;
        logic [31:0] a;
        logic [31:0] d;
        bit          fl;
        bit          e_en;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        int          e_lvl;
        int          e_wr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int          se [$];
        logic [31:0] sa [$];
        logic [31:0] got [$];
        int          k;
        int          maxlvl;
        logic [15:0] wr_before [NI];
        int          bad_strobes;

        //          v  addr    data          fl en e_addr  e_data        lvl wr
        tbl[0] = '{1, 32'h10, 32'hA5A5_0001, 0, 0, 32'h00, 32'h0000_0000, 1, 0};
        tbl[1] = '{0, 32'h00, 32'h0000_0000, 0, 1, 32'h10, 32'hA5A5_0001, 0, 1};
        tbl[2] = '{0, 32'h00, 32'h0000_0000, 0, 0, 32'h10, 32'hA5A5_0001, 0, 1};
        tbl[3] = '{1, 32'h00, 32'h0000_0100, 0, 0, 32'h10, 32'hA5A5_0001, 1, 1};
        tbl[4] = '{1, 32'h04, 32'h0000_0104, 0, 1, 32'h00, 32'h0000_0100, 1, 2};
        tbl[5] = '{1, 32'h08, 32'h0000_0108, 0, 1, 32'h04, 32'h0000_0104, 1, 3};
        tbl[6] = '{1, 32'h0C, 32'h0000_010C, 0, 1, 32'h08, 32'h0000_0108, 1, 4};
        tbl[7] = '{0, 32'h00, 32'h0000_0000, 0, 1, 32'h0C, 32'h0000_010C, 0, 5};
        tbl[8] = '{0, 32'h00, 32'h0000_0000, 0, 0, 32'h0C, 32'h0000_010C, 0, 5};

        rst       = 1'b0;
        req_valid = 1'b0;
        flush     = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < NI; i++) begin
            chk("rst_cfg_en",   i, cfg_en[i],     0);
            chk("rst_cfg_addr", i, cfg_addr[i],   0);
            chk("rst_cfg_data", i, cfg_data[i],   0);
            chk("rst_level",    i, fifo_level[i], 0);
            chk("rst_wr_count", i, wr_count[i],   0);
            chk("rst_busy",     i, busy[i],       0);
            chk("rst_ready",    i, req_ready[i],  1);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Single write and gapless burst
        for (int r = 0; r < 9; r++) begin
            req_valid = tbl[r].v;
            req_addr  = tbl[r].a;
            req_data  = tbl[r].d;
            flush     = tbl[r].fl;
            step();
            chk("tbl_en",   r, cfg_en[0],     tbl[r].e_en);
            chk("tbl_addr", r, cfg_addr[0],   tbl[r].e_addr);
            chk("tbl_data", r, cfg_data[0],   tbl[r].e_data);
            chk("tbl_lvl",  r, fifo_level[0], tbl[r].e_lvl);
            chk("tbl_wr",   r, wr_count[0],   tbl[r].e_wr);
        end
        drain();

        // Gap spacing on the GAP=3 instance
        for (int c = 0; c < 30; c++) begin
            req_valid = (c < 3);
            req_addr  = 32'h200 + 32'(c * 4);
            req_data  = 32'h2000 + 32'(c);
            step();
            if (cfg_en[1]) begin
                se.push_back(edge_n);
                sa.push_back(cfg_addr[1]);
            end else if (sa.size() > 0) begin
                chk("gap_hold", 1, cfg_addr[1], 32'h200 + 32'((sa.size() - 1) * 4));
            end
        end
        chk("gap_count", 1, se.size(), 3);
        for (int j = 0; j < sa.size(); j++) chk("gap_addr", j, sa[j], 32'h200 + 32'(j * 4));
        for (int j = 1; j < se.size(); j++) chk("gap_dist", j, se[j] - se[j-1], G1 + 1);
        drain();

        // Full backpressure on the GAP=5 instance
        k      = 0;
        maxlvl = 0;
        for (int c = 0; c < 90; c++) begin
            if (k == 8 && !m_busy(2)) break;
            req_valid = (k < 8);
            req_addr  = 32'h300 + 32'(k * 4);
            req_data  = 32'h3000 + 32'(k);
            step();
            if (req_valid && m_ready[2]) k++;
            if (int'(fifo_level[2]) > maxlvl) maxlvl = int'(fifo_level[2]);
            if (cfg_en[2]) got.push_back(cfg_addr[2]);
        end
        chk("bp_accepted", 2, k, 8);
        chk("bp_count", 2, got.size(), 8);
        for (int j = 0; j < got.size(); j++) chk("bp_order", j, got[j], 32'h300 + 32'(j * 4));
        chk("bp_max_level", 2, maxlvl, DEPTH);
        drain();

        // Flush during the first strobe
        for (int i = 0; i < NI; i++) wr_before[i] = m_wr[i];
        req_valid = 1'b1; req_addr = 32'h400; req_data = 32'h4000; step();
        req_valid = 1'b1; req_addr = 32'h404; req_data = 32'h4004; step();
        chk("fl_strobe_en",   2, cfg_en[2],   1);
        chk("fl_strobe_addr", 2, cfg_addr[2], 32'h400);
        req_valid = 1'b1; req_addr = 32'h408; req_data = 32'h4008; flush = 1'b1;
        #3;
        for (int i = 0; i < NI; i++) chk("fl_ready", i, req_ready[i], 0);
        #1;
        @(negedge clk);
        // step() re-samples req_ready one cycle later; realign to posedge+1
        @(posedge clk);
        #1;
        edge_n++;
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            has_l[i] = 1'b0;
            m_en[i]  = 1'b0;
            chk("fl_level", i, fifo_level[i], 0);
            chk("fl_en",    i, cfg_en[i],     0);
        end
        flush       = 1'b0;
        req_valid   = 1'b0;
        bad_strobes = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            for (int i = 0; i < NI; i++) if (cfg_en[i]) bad_strobes++;
        end
        chk("fl_no_replay", 0, bad_strobes, 0);
        for (int i = 0; i < NI; i++) chk("fl_wr_count", i, wr_count[i], wr_before[i] + 16'd1);

        // Asynchronous reset mid-burst, then 2-edge latency
        req_valid = 1'b1; req_addr = 32'h500; req_data = 32'h5000; step();
        req_valid = 1'b1; req_addr = 32'h504; req_data = 32'h5004; step();
        chk("ar_pre_en", 0, cfg_en[0], 1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("ar_cfg_en",   i, cfg_en[i],     0);
            chk("ar_cfg_addr", i, cfg_addr[i],   0);
            chk("ar_cfg_data", i, cfg_data[i],   0);
            chk("ar_wr_count", i, wr_count[i],   0);
            chk("ar_level",    i, fifo_level[i], 0);
            chk("ar_busy",     i, busy[i],       0);
        end
        model_reset();
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = 1'b1; req_addr = 32'h600; req_data = 32'h6000; step();
        chk("lat_edge_k", 0, cfg_en[0], 0);
        req_valid = 1'b0; step();
        chk("lat_edge_k1_en",   0, cfg_en[0],   1);
        chk("lat_edge_k1_addr", 0, cfg_addr[0], 32'h600);
        chk("lat_edge_k1_wr",   0, wr_count[0], 1);
        step();
        chk("lat_single", 0, cfg_en[0], 0);
        drain();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 9) < 6);
            req_addr  = $urandom;
            req_data  = $urandom;
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
